// File: rtl/latch_monitor.sv
// latch_monitor
// Watches the q/qbar outputs of an asynchronous latch from a clocked domain.
// Both inputs are synchronized, checked for complementarity, and tracked by a
// small FSM that reports edges as one-cycle pulses and keeps saturating
// counts. A sustained q == qbar condition latches a sticky error.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   q_in       : latch q output (asynchronous)
//   qbar_in    : latch qbar output (asynchronous)
//   clr        : synchronous clear of counters, error, pulses and FSM
//   q_sync     : synchronized q
//   rise_pulse : one cycle after a synchronized q rising edge
//   fall_pulse : one cycle after a synchronized q falling edge
//   rise_cnt   : saturating rising-edge count
//   fall_cnt   : saturating falling-edge count
//   err_flag   : sticky complementarity error
//   state      : 00 UNKNOWN, 01 LOW, 10 HIGH, 11 ERR
module latch_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_LEN     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q_in,
    input  logic             qbar_in,
    input  logic             clr,
    output logic             q_sync,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             err_flag,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_UNKNOWN = 2'b00;
    localparam logic [1:0] ST_LOW     = 2'b01;
    localparam logic [1:0] ST_HIGH    = 2'b10;
    localparam logic [1:0] ST_ERR     = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       ERR_THR = 4'(ERR_LEN);

    logic [SYNC_STAGES-1:0] q_chain;
    logic [SYNC_STAGES-1:0] qb_chain;
    // Fills with ones after reset; the top bit marks the point where the
    // synchronizer outputs carry real samples rather than reset zeros.
    // Without it the all-zero chains would look like q == qbar and could
    // trip the error right after reset.
    logic [SYNC_STAGES-1:0] primed;

    logic [3:0] inv_cnt;
    logic [3:0] inv_cnt_inc;
    logic [3:0] inv_nxt;

    logic qs;
    logic qbs;
    logic sample_ok;
    logic valid;
    logic err_hit;

    logic [1:0]       state_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic [CNT_W-1:0] rise_cnt_nxt;
    logic [CNT_W-1:0] fall_cnt_nxt;
    logic             err_nxt;

    assign qs        = q_chain[SYNC_STAGES-1];
    assign qbs       = qb_chain[SYNC_STAGES-1];
    assign q_sync    = qs;
    assign sample_ok = primed[SYNC_STAGES-1];
    assign valid     = qs ^ qbs;

    // Synchronizers are not touched by clr: they only carry the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_chain  <= '0;
            qb_chain <= '0;
            primed   <= '0;
        end else begin
            q_chain  <= {q_chain[SYNC_STAGES-2:0], q_in};
            qb_chain <= {qb_chain[SYNC_STAGES-2:0], qbar_in};
            primed   <= {primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Consecutive-invalid counter; saturates at 15 so it never wraps back
    // below the threshold during a long bad stretch.
    always_comb begin
        inv_cnt_inc = (inv_cnt == 4'hF) ? 4'hF : inv_cnt + 4'd1;
        if (!sample_ok || valid) begin
            inv_nxt = 4'd0;
        end else begin
            inv_nxt = inv_cnt_inc;
        end
    end

    // The error fires on the edge that processes the ERR_LEN-th consecutive
    // invalid sample.
    assign err_hit = sample_ok && !valid && (inv_nxt >= ERR_THR) && (state != ST_ERR);

    always_comb begin
        state_nxt    = state;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;
        rise_cnt_nxt = rise_cnt;
        fall_cnt_nxt = fall_cnt;
        err_nxt      = err_flag;
        if (clr) begin
            state_nxt    = ST_UNKNOWN;
            rise_cnt_nxt = '0;
            fall_cnt_nxt = '0;
            err_nxt      = 1'b0;
        end else if (err_hit) begin
            state_nxt = ST_ERR;
            err_nxt   = 1'b1;
        end else if (sample_ok && valid) begin
            case (state)
                ST_UNKNOWN: state_nxt = qs ? ST_HIGH : ST_LOW;
                ST_LOW: begin
                    if (qs) begin
                        state_nxt    = ST_HIGH;
                        rise_nxt     = 1'b1;
                        rise_cnt_nxt = (rise_cnt == CNT_MAX) ? CNT_MAX : rise_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!qs) begin
                        state_nxt    = ST_LOW;
                        fall_nxt     = 1'b1;
                        fall_cnt_nxt = (fall_cnt == CNT_MAX) ? CNT_MAX : fall_cnt + 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_UNKNOWN;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            rise_cnt   <= '0;
            fall_cnt   <= '0;
            err_flag   <= 1'b0;
            inv_cnt    <= 4'd0;
        end else begin
            state      <= state_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            rise_cnt   <= rise_cnt_nxt;
            fall_cnt   <= fall_cnt_nxt;
            err_flag   <= err_nxt;
            inv_cnt    <= clr ? 4'd0 : inv_nxt;
        end
    end

endmodule

// File: tb/tb_latch_monitor.sv
// Self-checking bench for latch_monitor with default parameters.
module tb_latch_monitor;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ERR_LEN     = 2;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic             q_in;
    logic             qbar_in;
    logic             clr;
    logic             q_sync;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic             err_flag;
    logic [1:0]       state;

    int checks;
    int errors;

    latch_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .ERR_LEN(ERR_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .q_in(q_in), .qbar_in(qbar_in), .clr(clr),
        .q_sync(q_sync), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .err_flag(err_flag), .state(state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " state"}, int'(state), 0);
        check({tag, " rise_pulse"}, int'(rise_pulse), 0);
        check({tag, " fall_pulse"}, int'(fall_pulse), 0);
        check({tag, " rise_cnt"}, int'(rise_cnt), 0);
        check({tag, " fall_cnt"}, int'(fall_cnt), 0);
        check({tag, " err_flag"}, int'(err_flag), 0);
        check({tag, " q_sync"}, int'(q_sync), 0);
    endtask

    task automatic do_reset(input logic q0, input logic qb0);
        q_in    = q0;
        qbar_in = qb0;
        clr     = 1'b0;
        rst_n   = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- reference model ----------------
    // Sample seen by the monitor at an edge is the input pair captured
    // SYNC_STAGES edges earlier; samples before that are reset filler.
    logic [1:0] m_hist[$];
    int m_edges, m_mode, m_inv, m_rc, m_fc, m_rp, m_fp, m_err, m_qs;

    task automatic model_reset();
        m_hist.delete();
        m_edges = 0; m_mode = 0; m_inv = 0; m_rc = 0; m_fc = 0;
        m_rp = 0; m_fp = 0; m_err = 0; m_qs = 0;
    endtask

    task automatic model_edge(input logic q, input logic qb, input logic c);
        logic [1:0] s;
        bit primed;
        m_edges++;
        m_hist.push_back({q, qb});
        primed = (m_edges > SYNC_STAGES);
        s = primed ? m_hist[m_hist.size()-1-SYNC_STAGES] : 2'b00;
        m_qs = (m_edges >= SYNC_STAGES) ? int'(m_hist[m_hist.size()-SYNC_STAGES][1]) : 0;
        if (m_hist.size() > SYNC_STAGES + 1) void'(m_hist.pop_front());
        m_rp = 0;
        m_fp = 0;
        if (c) begin
            m_mode = 0; m_inv = 0; m_rc = 0; m_fc = 0; m_err = 0;
        end else if (primed) begin
            if (s[1] != s[0]) begin
                m_inv = 0;
                if (m_mode == 0) m_mode = s[1] ? 2 : 1;
                else if (m_mode == 1 && s[1]) begin
                    m_mode = 2; m_rp = 1; m_rc = (m_rc < CMAX) ? m_rc + 1 : CMAX;
                end else if (m_mode == 2 && !s[1]) begin
                    m_mode = 1; m_fp = 1; m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
                end
            end else begin
                m_inv = (m_inv < 15) ? m_inv + 1 : 15;
                if (m_mode != 3 && m_inv >= ERR_LEN) begin
                    m_mode = 3; m_err = 1;
                end
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       q, qb, c;
        logic [1:0] st;
        logic       rp, fp;
        int         rc, fc;
        logic       err, qsy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b1;
        rst_n  = 1'b0;
        q_in = 1'b0; qbar_in = 1'b1; clr = 1'b0;

        //             q     qb    clr   st     rp    fp    rc fc err   qsync
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1, 1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2, 1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2, 1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2, 1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};

        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("tbl[%0d]", i);
            q_in = tbl[i].q; qbar_in = tbl[i].qb; clr = tbl[i].c;
            tick();
            check({tag, " state"}, int'(state), int'(tbl[i].st));
            check({tag, " rise_pulse"}, int'(rise_pulse), int'(tbl[i].rp));
            check({tag, " fall_pulse"}, int'(fall_pulse), int'(tbl[i].fp));
            check({tag, " rise_cnt"}, int'(rise_cnt), tbl[i].rc);
            check({tag, " fall_cnt"}, int'(fall_cnt), tbl[i].fc);
            check({tag, " err_flag"}, int'(err_flag), int'(tbl[i].err));
            check({tag, " q_sync"}, int'(q_sync), int'(tbl[i].qsy));
        end
        clr = 1'b0;

        // ---------------- clr in the same cycle as a detected rise ----------------
        do_reset(1'b0, 1'b1);
        repeat (4) tick();
        check("clr_rise pre state", int'(state), 1);
        q_in = 1'b1; qbar_in = 1'b0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_rise state", int'(state), 0);
        check("clr_rise rise_pulse", int'(rise_pulse), 0);
        check("clr_rise rise_cnt", int'(rise_cnt), 0);
        tick();
        check("clr_rise after state", int'(state), 2);
        check("clr_rise after pulse", int'(rise_pulse), 0);

        // ---------------- latency, then async reset with clock stopped ----------------
        do_reset(1'b0, 1'b1);
        repeat (4) tick();
        q_in = 1'b1; qbar_in = 1'b0;
        tick();
        check("lat edge k pulse", int'(rise_pulse), 0);
        tick();
        check("lat edge k+1 pulse", int'(rise_pulse), 0);
        tick();
        check("lat edge k+2 pulse", int'(rise_pulse), 1);
        check("lat edge k+2 state", int'(state), 2);
        check("lat edge k+2 cnt", int'(rise_cnt), 1);
        tick();
        check("lat edge k+3 pulse", int'(rise_pulse), 0);
        for (int i = 0; i < 4; i++) begin
            q_in = 1'b0; qbar_in = 1'b1; repeat (3) tick();
            q_in = 1'b1; qbar_in = 1'b0; repeat (3) tick();
        end
        check("midcount rise_cnt", int'(rise_cnt), 5);
        q_in = 1'b0; qbar_in = 1'b0;
        clk_en = 1'b0;
        #20;
        rst_n = 1'b0;
        #2;
        check_all_zero("async");
        clk_en = 1'b1;

        // ---------------- saturation ----------------
        do_reset(1'b0, 1'b1);
        repeat (4) tick();
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 260; i++) begin
                q_in = 1'b1; qbar_in = 1'b0;
                repeat (2) begin tick(); pulses += int'(rise_pulse); end
                q_in = 1'b0; qbar_in = 1'b1;
                repeat (2) begin tick(); pulses += int'(rise_pulse); end
            end
            repeat (4) begin tick(); pulses += int'(rise_pulse); end
            check("sat rise pulses", pulses, 260);
        end
        check("sat rise_cnt", int'(rise_cnt), CMAX);
        check("sat fall_cnt", int'(fall_cnt), CMAX);
        check("sat state", int'(state), 1);

        // ---------------- randomized against the model ----------------
        do_reset(1'b0, 1'b1);
        begin
            logic q_cur;
            int bad_left;
            q_cur = 1'b0;
            bad_left = 0;
            for (int n = 0; n < 1500; n++) begin
                int r;
                logic qb_cur;
                r = int'($urandom_range(0, 99));
                if (r < 30) q_cur = ~q_cur;
                if (bad_left == 0 && $urandom_range(0, 99) < 4)
                    bad_left = int'($urandom_range(1, 3));
                if (bad_left > 0) begin
                    qb_cur = q_cur;
                    bad_left--;
                end else begin
                    qb_cur = ~q_cur;
                end
                q_in = q_cur; qbar_in = qb_cur;
                clr = ($urandom_range(0, 99) < 3);
                tick();
                model_edge(q_in, qbar_in, clr);
                check("rnd state", int'(state), m_mode);
                check("rnd rise_pulse", int'(rise_pulse), m_rp);
                check("rnd fall_pulse", int'(fall_pulse), m_fp);
                check("rnd rise_cnt", int'(rise_cnt), m_rc);
                check("rnd fall_cnt", int'(fall_cnt), m_fc);
                check("rnd err_flag", int'(err_flag), m_err);
                check("rnd q_sync", int'(q_sync), m_qs);
            end
            clr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
